icb2apb_bridge: RTL

- Converts one ICB master channel into an APB4 master transaction. One instance sits on each output channel of the ICB splitter and drives one APB peripheral (1553B core registers, timers, etc.).
- Exactly one transfer is in flight at a time. The bridge uses a 4-state FSM.
- An optional access-timeout counter ends hung APB accesses with an error response.

---
 rtl/icb2apb_bridge_if.sv | 53 +++++
 rtl/icb2apb_bridge.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/icb2apb_bridge_if.sv
// Bus bundles for the ICB-to-APB bridge: one ICB command/response channel and
// one APB4 master port, each with master/slave modports.
interface icb2apb_icb_if #(
  parameter int unsigned AW    = 32'd32,
  parameter int unsigned DW    = 32'd32,
  parameter int unsigned USR_W = 32'd1
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic              cmd_read;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic [DW/8-1:0]   cmd_wmask;
  logic [USR_W-1:0]  cmd_usr;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic              rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [USR_W-1:0]  rsp_usr;

  modport master (
    output cmd_vld, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_usr, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_err, rsp_rdata, rsp_usr
  );
  modport slave (
    input  cmd_vld, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_usr, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_err, rsp_rdata, rsp_usr
  );
endinterface

interface icb2apb_apb_if #(
  parameter int unsigned AW = 32'd32,
  parameter int unsigned DW = 32'd32
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/icb2apb_bridge.sv
// ICB-to-APB4 bridge: one transfer in flight, fully registered APB and ICB
// response outputs, optional access timeout that ends hung accesses with an error.
module icb2apb_bridge #(
  parameter int unsigned AW      = 32'd32,
  parameter int unsigned DW      = 32'd32,
  parameter int unsigned USR_W   = 32'd1,
  parameter int unsigned TIMEOUT = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  icb2apb_icb_if.slave         i_icb,
  icb2apb_apb_if.master        apb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RSP    = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  state_t            state_r;
  logic              read_r;
  logic [15:0]       tmo_cnt_r;
  logic              psel_r;
  logic              penable_r;
  logic              pwrite_r;
  logic [AW-1:0]     paddr_r;
  logic [DW-1:0]     pwdata_r;
  logic [DW/8-1:0]   pstrb_r;
  logic              rsp_vld_r;
  logic              rsp_err_r;
  logic [DW-1:0]     rsp_rdata_r;
  logic [USR_W-1:0]  rsp_usr_r;
  logic              tmo_hit_s;
  logic [15:0]       tmo_cnt_inc_s;

  // Timeout fires on the ACCESS cycle that would bring the count up to the limit.
  always_comb begin
    tmo_hit_s     = 1'b0;
    tmo_cnt_inc_s = tmo_cnt_r;
    if (tmo_cnt_r != 16'hFFFF) begin
      tmo_cnt_inc_s = tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_inc_s = tmo_cnt_r;
    end
    if (TIMEOUT != 32'd0) begin
      tmo_hit_s = (tmo_cnt_r >= (TMO_LIMIT - 16'd1));
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Transfer FSM; every bus-facing output is a register updated on state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      read_r      <= 1'b0;
      tmo_cnt_r   <= 16'd0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {AW{1'b0}};
      pwdata_r    <= {DW{1'b0}};
      pstrb_r     <= {(DW/8){1'b0}};
      rsp_vld_r   <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DW{1'b0}};
      rsp_usr_r   <= {USR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (i_icb.cmd_vld) begin
            read_r    <= i_icb.cmd_read;
            psel_r    <= 1'b1;
            pwrite_r  <= ~i_icb.cmd_read;
            paddr_r   <= i_icb.cmd_addr;
            pwdata_r  <= i_icb.cmd_wdata;
            pstrb_r   <= i_icb.cmd_read ? {(DW/8){1'b0}} : i_icb.cmd_wmask;
            rsp_usr_r <= i_icb.cmd_usr;
            state_r   <= SETUP;
          end else begin
            state_r   <= IDLE;
          end
        end
        SETUP: begin
          penable_r <= 1'b1;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          if (apb.pready) begin
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_vld_r   <= 1'b1;
            rsp_err_r   <= apb.pslverr;
            rsp_rdata_r <= read_r ? apb.prdata : {DW{1'b0}};
            state_r     <= RSP;
          end else if (tmo_hit_s) begin
            tmo_cnt_r   <= tmo_cnt_inc_s;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_vld_r   <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= {DW{1'b0}};
            state_r     <= RSP;
          end else begin
            tmo_cnt_r   <= tmo_cnt_inc_s;
            state_r     <= ACCESS;
          end
        end
        RSP: begin
          if (i_icb.rsp_rdy) begin
            rsp_vld_r <= 1'b0;
            tmo_cnt_r <= 16'd0;
            state_r   <= IDLE;
          end else begin
            state_r   <= RSP;
          end
        end
        default: begin
          psel_r    <= 1'b0;
          penable_r <= 1'b0;
          rsp_vld_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign i_icb.cmd_rdy   = (state_r == IDLE);
  assign i_icb.rsp_vld   = rsp_vld_r;
  assign i_icb.rsp_err   = rsp_err_r;
  assign i_icb.rsp_rdata = rsp_rdata_r;
  assign i_icb.rsp_usr   = rsp_usr_r;

  assign apb.psel        = psel_r;
  assign apb.penable     = penable_r;
  assign apb.pwrite      = pwrite_r;
  assign apb.paddr       = paddr_r;
  assign apb.pwdata      = pwdata_r;
  assign apb.pstrb       = pstrb_r;

endmodule
